// File: rtl/serial_link_pkg.sv
// Shared serial link definitions.
// Used by both ends of the byte-serial link.
package serial_link_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t DATA = 2'd1;
    localparam state_t STOP = 2'd2;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Parallel word handshake between the receiver
// and its consumer.
interface serial_frame_receiver_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/serial_frame_receiver_sipo_shift_reg.sv
// Serial-in/parallel-out register, shifting right,
// new bit enters at the MSB.
module sipo_shift_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  shift_en,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else if (shift_en) begin
            data <= {serial_in, data[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_frame_receiver.sv
// Byte-serial receive end: start/stop framing, SIPO
// capture and a one-entry valid/ready output buffer.
module serial_frame_receiver
    import serial_link_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           serial_in,
    input  logic                           bit_en,
    input  logic                           err_clear,
    serial_frame_receiver_if.master        rx,
    output logic                           busy,
    output logic                           frame_error,
    output logic                           overrun
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;

    logic shift_en;
    logic cnt_clr;
    logic cnt_inc;
    logic good_stop;
    logic bad_stop;
    logic can_load;

    sipo_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sipo (
        .clock     (clock),
        .reset_n   (reset_n),
        .shift_en  (shift_en),
        .serial_in (serial_in),
        .data      (shift_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (bit_en && serial_in != LINE_IDLE) begin
                    state_d = DATA;
                end
            end
            (state_q == DATA): begin
                if (bit_en && cnt_q == LAST_BIT) begin
                    state_d = STOP;
                end
            end
            (state_q == STOP): begin
                if (bit_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): begin
                cnt_clr = bit_en && (serial_in != LINE_IDLE);
            end
            (state_q == DATA): begin
                shift_en = bit_en;
                cnt_inc  = bit_en;
            end
            (state_q == STOP): begin
                good_stop = bit_en && (serial_in == LINE_IDLE);
                bad_stop  = bit_en && (serial_in != LINE_IDLE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (cnt_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Buffer can take a new word if empty or drained this cycle.
    assign can_load = !rx.data_valid || rx.data_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx.data_out   <= '0;
            rx.data_valid <= 1'b0;
        end else if (good_stop && can_load) begin
            rx.data_out   <= shift_q;
            rx.data_valid <= 1'b1;
        end else if (rx.data_valid && rx.data_ready) begin
            rx.data_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_error <= 1'b0;
        end else begin
            frame_error <= bad_stop;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (good_stop && !can_load) begin
            overrun <= 1'b1;
        end else if (err_clear) begin
            overrun <= 1'b0;
        end
    end

endmodule
